// File: rtl/trace_pkg.sv
// Shared types for the write-back trace checker: FSM states, error codes and
// the golden trace entry layout.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MISMATCH  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  // Destination register field is named rd because reg is a keyword.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        last;
  } trace_entry_t;

  function automatic logic entry_match(input trace_entry_t e,
                                       input logic [31:0]  pc,
                                       input logic [4:0]   rd,
                                       input logic [31:0]  value);
    return (e.pc == pc) && (e.rd == rd) && (e.value == value);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of golden trace entries; no push-to-head bypass, so an entry
// written at one edge is visible at the head from the next cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output trace_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_entry_t   r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/trace_checker.sv
// Compares every committed CPU register write against a streamed golden trace,
// latching the first error and flagging stalls with a watchdog.
module trace_checker
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             check_en,
  input  logic [31:0]      debug_wb_pc,
  input  logic             debug_wb_ena,
  input  logic [4:0]       debug_wb_reg,
  input  logic [31:0]      debug_wb_value,
  input  logic             gold_valid,
  output logic             gold_ready,
  input  logic [31:0]      gold_pc,
  input  logic [4:0]       gold_reg,
  input  logic [31:0]      gold_value,
  input  logic             gold_last,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [31:0]      err_pc,
  output logic [4:0]       err_reg,
  output logic [31:0]      err_exp,
  output logic [31:0]      err_got,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic [WD_W-1:0]    r_wd;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_err_code;
  logic [31:0]        r_err_pc;
  logic [4:0]         r_err_reg;
  logic [31:0]        r_err_exp;
  logic [31:0]        r_err_got;

  state_t             w_state_nxt;
  logic [WD_W-1:0]    w_wd_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_fail;
  logic [1:0]         w_fail_code;
  logic [31:0]        w_fail_exp;

  logic               w_commit;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  trace_entry_t       w_din;
  trace_entry_t       w_head;

  assign w_commit = debug_wb_ena && (debug_wb_reg != 5'd0);
  assign w_push   = gold_valid && !w_full;
  assign w_pop    = (r_state == ST_RUN) && check_en && w_commit && !w_empty;
  assign w_din    = '{pc: gold_pc, rd: gold_reg, value: gold_value, last: gold_last};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_cnt_nxt   = r_cnt;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    w_fail_exp  = '0;
    unique case (r_state)
      ST_IDLE: if (check_en) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!check_en) begin
          w_state_nxt = ST_IDLE;
          w_wd_nxt    = '0;
        end else if (w_commit) begin
          if (w_empty) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_UNDERFLOW;
          end else if (entry_match(w_head, debug_wb_pc, debug_wb_reg, debug_wb_value)) begin
            if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
            w_wd_nxt = '0;
            if (w_head.last) w_state_nxt = ST_PASS;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_MISMATCH;
            w_fail_exp  = w_head.value;
          end
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
        if (w_fail) w_state_nxt = ST_FAIL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wd       <= '0;
      r_cnt      <= '0;
      r_err_code <= ERR_NONE;
      r_err_pc   <= '0;
      r_err_reg  <= '0;
      r_err_exp  <= '0;
      r_err_got  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      r_cnt   <= w_cnt_nxt;
      // Error fields load only on the edge entering FAIL, then stay frozen.
      if (w_fail) begin
        r_err_code <= w_fail_code;
        r_err_pc   <= debug_wb_pc;
        r_err_reg  <= debug_wb_reg;
        r_err_exp  <= w_fail_exp;
        r_err_got  <= debug_wb_value;
      end
    end
  end

  assign gold_ready = !w_full;
  assign done       = (r_state == ST_PASS) || (r_state == ST_FAIL);
  assign pass       = (r_state == ST_PASS);
  assign err_code   = r_err_code;
  assign err_pc     = r_err_pc;
  assign err_reg    = r_err_reg;
  assign err_exp    = r_err_exp;
  assign err_got    = r_err_got;
  assign commit_cnt = r_cnt;

endmodule
